accel_avg_filter: RTL and testbench

- Moving-average filter stage between the IMU interface (10-bit accelerometer samples plus a DataValid strobe) and the PWM generator (10-bit unsigned duty input).
- On each new sample it updates a 2^LOG2_DEPTH-deep running sum and computes the average.
- It converts the signed average to offset binary, clamps it, and holds the result on PWMinput until the next update.

---
 rtl/accel_avg_filter_pkg.sv | 18 +
 rtl/accel_avg_filter_sample_ring_buffer.sv | 43 ++++
 rtl/accel_avg_filter.sv | 125 ++++++++++++
 tb/tb_accel_avg_filter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/accel_avg_filter_pkg.sv
// Shared widths, output scaling defaults and FSM encoding for the accelerometer
// moving-average filter.
package accel_filter_pkg;

    localparam int DATA_W_DEF     = 10;
    localparam int LOG2_DEPTH_DEF = 3;
    localparam int OUT_OFFSET_DEF = 512;
    localparam int OUT_MIN_DEF    = 0;
    localparam int OUT_MAX_DEF    = 1023;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        UPDATE = 2'd2,
        OUTPUT = 2'd3
    } state_t;

endpackage

// File: rtl/accel_avg_filter_sample_ring_buffer.sv
// Sample history for the moving average: one registered read port, one write
// port, every entry cleared while key is low.
module sample_ring_buffer #(
    parameter int DATA_W     = 10,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  key,
    input  logic                  rd_en,
    input  logic [LOG2_DEPTH-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [LOG2_DEPTH-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data
);

    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    // Per-entry registers so the whole history clears in a single reset cycle.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (!key) begin
                mem_reg[gi] <= '0;
            end else if (wr_en && (wr_addr == LOG2_DEPTH'(gi))) begin
                mem_reg[gi] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!key) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem_reg[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/accel_avg_filter.sv
// Moving-average filter between the IMU sample stream and the PWM duty input:
// running sum over a 2^LOG2_DEPTH window, offset to unsigned, clamped.
module accel_avg_filter
    import accel_filter_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LOG2_DEPTH = LOG2_DEPTH_DEF,
    parameter int OUT_OFFSET = OUT_OFFSET_DEF,
    parameter int OUT_MIN    = OUT_MIN_DEF,
    parameter int OUT_MAX    = OUT_MAX_DEF
) (
    input  logic                     CLOCK_50,
    input  logic                     KEY,
    input  logic signed [DATA_W-1:0] AccelX,
    input  logic                     DataValid,
    output logic        [DATA_W-1:0] PWMinput,
    output logic                     FilterValid,
    output logic                     Overrun
);

    localparam int SUM_W = DATA_W + LOG2_DEPTH;
    localparam int VAL_W = SUM_W + 1;
    localparam logic signed [VAL_W-1:0] OUT_MIN_V = VAL_W'(OUT_MIN);
    localparam logic signed [VAL_W-1:0] OUT_MAX_V = VAL_W'(OUT_MAX);

    state_t                   state_reg;
    logic                     dv_q_reg;
    logic                     rise;
    logic signed [DATA_W-1:0] sample_reg;
    logic        [DATA_W-1:0] old_q;
    logic signed [SUM_W-1:0]  sum_reg;
    logic signed [SUM_W-1:0]  sum_next;
    logic signed [SUM_W-1:0]  avg;
    logic signed [VAL_W-1:0]  val;
    logic [LOG2_DEPTH-1:0]    wr_ptr_reg;
    logic [DATA_W-1:0]        pwm_reg;
    logic [DATA_W-1:0]        pwm_next;
    logic                     fv_reg;
    logic                     ovr_reg;
    logic                     rd_en;
    logic                     wr_en;

    assign rise  = DataValid & ~dv_q_reg;
    assign rd_en = (state_reg == IDLE) && rise;
    assign wr_en = (state_reg == UPDATE);

    sample_ring_buffer #(
        .DATA_W     (DATA_W),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ring (
        .clk     (CLOCK_50),
        .key     (KEY),
        .rd_en   (rd_en),
        .rd_addr (wr_ptr_reg),
        .rd_data (old_q),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg),
        .wr_data (sample_reg)
    );

    // The duty value is derived from the new sum during UPDATE so that it is
    // already registered and visible for the whole OUTPUT cycle.
    assign sum_next = sum_reg
                    - {{LOG2_DEPTH{old_q[DATA_W-1]}}, old_q}
                    + {{LOG2_DEPTH{sample_reg[DATA_W-1]}}, sample_reg};
    assign avg      = sum_next >>> LOG2_DEPTH;
    assign val      = {avg[SUM_W-1], avg} + VAL_W'(OUT_OFFSET);

    always_comb begin
        pwm_next = val[DATA_W-1:0];
        if (val < OUT_MIN_V) begin
            pwm_next = DATA_W'(OUT_MIN);
        end else if (val > OUT_MAX_V) begin
            pwm_next = DATA_W'(OUT_MAX);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!KEY) begin
            state_reg  <= IDLE;
            dv_q_reg   <= 1'b0;
            sample_reg <= '0;
            sum_reg    <= '0;
            wr_ptr_reg <= '0;
            pwm_reg    <= DATA_W'(OUT_OFFSET);
            fv_reg     <= 1'b0;
            ovr_reg    <= 1'b0;
        end else begin
            dv_q_reg <= DataValid;
            fv_reg   <= 1'b0;
            if (rise && (state_reg != IDLE)) begin
                ovr_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (rise) begin
                        sample_reg <= AccelX;
                        state_reg  <= READ;
                    end
                end
                READ: begin
                    state_reg <= UPDATE;
                end
                UPDATE: begin
                    sum_reg    <= sum_next;
                    wr_ptr_reg <= wr_ptr_reg + LOG2_DEPTH'(1);
                    pwm_reg    <= pwm_next;
                    fv_reg     <= 1'b1;
                    state_reg  <= OUTPUT;
                end
                OUTPUT: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign PWMinput    = pwm_reg;
    assign FilterValid = fv_reg;
    assign Overrun     = ovr_reg;

endmodule

// File: tb/tb_accel_avg_filter.sv
// Directed bench for accel_avg_filter: a window-average model checked every
// cycle against two instances (default clamp and OUT_MAX=900).
module tb_accel_avg_filter;

    logic              clk = 1'b0;
    logic              key;
    logic signed [9:0] accel;
    logic              dv;
    logic [9:0]        pwm_a, pwm_b;
    logic              fv_a, fv_b, ovr_a, ovr_b;

    int nvec = 0;
    int nerr = 0;
    int fv_count = 0;

    // Behavioural model state
    int ring [8];
    int ptr, msum, cnt, pend_a, pend_b;
    int exp_pwm_a, exp_pwm_b;
    bit exp_fv, exp_ovr, prev_dv;

    always #10 clk = ~clk;

    accel_avg_filter dut_a (
        .CLOCK_50    (clk),
        .KEY         (key),
        .AccelX      (accel),
        .DataValid   (dv),
        .PWMinput    (pwm_a),
        .FilterValid (fv_a),
        .Overrun     (ovr_a)
    );

    accel_avg_filter #(.OUT_MAX(900)) dut_b (
        .CLOCK_50    (clk),
        .KEY         (key),
        .AccelX      (accel),
        .DataValid   (dv),
        .PWMinput    (pwm_b),
        .FilterValid (fv_b),
        .Overrun     (ovr_b)
    );

    function automatic int floor_div8(input int s);
        int q;
        q = s / 8;
        if ((s % 8 != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic chk(input string name, input int got, input int expv);
        nvec++;
        if (got != expv) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, expv, $time);
        end
    endtask

    // Model: a new sample is accepted only when the previous one has finished
    // (3 cycles after acceptance); its result appears 3 cycles after the rise.
    task automatic model_step();
        int cb;
        int v;
        if (!key) begin
            for (int i = 0; i < 8; i++) ring[i] = 0;
            ptr = 0; msum = 0; cnt = 0;
            exp_pwm_a = 512; exp_pwm_b = 512;
            exp_fv = 0; exp_ovr = 0; prev_dv = 0;
        end else begin
            cb = cnt;
            exp_fv = 0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 1) begin
                    exp_pwm_a = pend_a;
                    exp_pwm_b = pend_b;
                    exp_fv = 1;
                end
            end
            if (dv && !prev_dv) begin
                if (cb == 0) begin
                    msum = msum - ring[ptr] + int'(accel);
                    ring[ptr] = int'(accel);
                    ptr = (ptr + 1) % 8;
                    v = floor_div8(msum) + 512;
                    pend_a = clamp(v, 0, 1023);
                    pend_b = clamp(v, 0, 900);
                    cnt = 3;
                end else begin
                    exp_ovr = 1;
                end
            end
            prev_dv = dv;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (fv_a) fv_count++;
            chk("pwm_a", int'(pwm_a), exp_pwm_a);
            chk("pwm_b", int'(pwm_b), exp_pwm_b);
            chk("fv_a", int'(fv_a), int'(exp_fv));
            chk("fv_b", int'(fv_b), int'(exp_fv));
            chk("ovr_a", int'(ovr_a), int'(exp_ovr));
            chk("ovr_b", int'(ovr_b), int'(exp_ovr));
        end
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        key = 1'b0;
        dv  = 1'b0;
        repeat (n) @(negedge clk);
        key = 1'b1;
    endtask

    // One DataValid pulse; exp < 0 skips the literal duty check.
    task automatic send(input int val, input int exp_a, input int exp_b);
        @(negedge clk);
        accel = 10'(val);
        dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("fv_latency", int'(fv_a), 1);
        if (exp_a >= 0) chk("lit_pwm_a", int'(pwm_a), exp_a);
        if (exp_b >= 0) chk("lit_pwm_b", int'(pwm_b), exp_b);
        $display("sample %0d -> PWMinput %0d (clamp900 %0d) fv=%0b ovr=%0b",
                 val, pwm_a, pwm_b, fv_a, ovr_a);
        repeat (6) @(negedge clk);
    endtask

    int warm [8] = '{524, 537, 549, 562, 574, 587, 599, 612};
    int fv_start;

    initial begin
        key = 1'b0; dv = 1'b0; accel = '0;
        repeat (3) @(negedge clk);
        key = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_pwm", int'(pwm_a), 512);
        chk("rst_fv", int'(fv_a), 0);
        chk("rst_ovr", int'(ovr_a), 0);

        for (int i = 0; i < 8; i++) send(100, warm[i], warm[i]);
        send(0, 599, 599);

        do_reset(2);
        send(-1, 511, 511);

        do_reset(2);
        for (int i = 0; i < 7; i++) send(-512, -1, -1);
        send(-512, 0, 0);

        do_reset(2);
        for (int i = 0; i < 7; i++) send(511, -1, -1);
        send(511, 1023, 900);

        do_reset(2);
        fv_start = fv_count;
        @(negedge clk);
        accel = 10'sd80;
        dv = 1'b1;
        repeat (50) @(negedge clk);
        dv = 1'b0;
        repeat (5) @(negedge clk);
        chk("hold_one_update", fv_count - fv_start, 1);
        chk("hold_pwm", int'(pwm_a), 522);
        $display("hold 80 x50 -> PWMinput %0d updates %0d", pwm_a, fv_count - fv_start);

        fv_start = fv_count;
        @(negedge clk); dv = 1'b1;
        @(negedge clk); dv = 1'b0;
        @(negedge clk); dv = 1'b1;
        @(negedge clk); dv = 1'b0;
        repeat (8) @(negedge clk);
        chk("drop_one_update", fv_count - fv_start, 1);
        chk("drop_overrun", int'(ovr_a), 1);
        chk("drop_pwm", int'(pwm_a), 532);
        $display("dv 1,0,1 -> PWMinput %0d updates %0d ovr=%0b", pwm_a, fv_count - fv_start, ovr_a);

        do_reset(2);
        fv_start = fv_count;
        @(negedge clk); accel = 10'sd50; dv = 1'b1;
        @(negedge clk); dv = 1'b0;
        @(negedge clk); key = 1'b0;
        @(negedge clk); key = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_fv", fv_count - fv_start, 0);
        chk("abort_pwm", int'(pwm_a), 512);
        chk("abort_ovr", int'(ovr_a), 0);
        $display("reset in UPDATE -> PWMinput %0d updates %0d", pwm_a, fv_count - fv_start);
        send(100, 524, 524);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
